// File: rtl/stack_seq.sv
// Command sequencer for the 4-bit hardware stack: one op at a time, LIFO strobe spacing, 4-bit ALU.
// Optional DUP/SWAP support is built only when STACK_SEQ_EXT_OPS_EN is defined.
module stack_seq #(
  parameter int DEPTH   = 256,
  parameter int CNT_W   = 9,
  parameter int POP_LAT = 3
) (
  input  logic             clk,
  input  logic             nReset,
  // Command handshake: a command transfers on a rising edge where CMD_VALID and CMD_READY are
  // both high; CMD_READY is high only while idle. Results are single-cycle pulses, no backpressure.
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [2:0]       CMD_OP,
  input  logic [3:0]       CMD_DATA,
  output logic             RES_VALID,
  output logic [3:0]       RES_DATA,
  output logic             ERR,
  output logic [CNT_W-1:0] DEPTH_CNT,
  output logic [3:0]       STK_DIN,
  output logic             STK_WE,
  output logic             STK_RE,
  input  logic [3:0]       STK_DOUT
);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_POP  = 3'd2;
  localparam logic [2:0] OP_ADD  = 3'd3;
  localparam logic [2:0] OP_SUB  = 3'd4;
  localparam logic [2:0] OP_DUP  = 3'd5;
  localparam logic [2:0] OP_SWAP = 3'd6;
  localparam logic [2:0] OP_PEEK = 3'd7;

  localparam int WAIT_W = (POP_LAT > 1) ? $clog2(POP_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_POP_A  = 3'd1,
    S_WAIT_A = 3'd2,
    S_POP_B  = 3'd3,
    S_WAIT_B = 3'd4,
    S_PUSH1  = 3'd5,
`ifdef STACK_SEQ_EXT_OPS_EN
    S_PUSH2  = 3'd6,
`endif
    S_DONE   = 3'd7
  } state_t;

  state_t            state;
  logic [2:0]        op_q;
  logic [3:0]        a_q;
`ifdef STACK_SEQ_EXT_OPS_EN
  logic [3:0]        b_q;
`endif
  logic [WAIT_W-1:0] wait_q;
  logic              rej;
  logic [CNT_W-1:0]  delta;

  assign CMD_READY = (state == S_IDLE);

  // Accept-time legality against the committed occupancy, never the LIFO's lagging flags.
  always_comb begin
    rej = 1'b0;
    case (CMD_OP)
      OP_PUSH:          rej = (DEPTH_CNT == CNT_W'(DEPTH));
      OP_POP, OP_PEEK:  rej = (DEPTH_CNT == '0);
      OP_ADD, OP_SUB:   rej = (DEPTH_CNT < CNT_W'(2));
`ifdef STACK_SEQ_EXT_OPS_EN
      OP_DUP:           rej = (DEPTH_CNT == '0) || (DEPTH_CNT == CNT_W'(DEPTH));
      OP_SWAP:          rej = (DEPTH_CNT < CNT_W'(2));
`else
      OP_DUP, OP_SWAP:  rej = 1'b1;
`endif
      default:          rej = 1'b0;
    endcase
  end

  always_comb begin
    delta = '0;
    case (op_q)
      OP_PUSH, OP_DUP:         delta = CNT_W'(1);
      OP_POP, OP_ADD, OP_SUB:  delta = '1;
      default:                 delta = '0;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state     <= S_IDLE;
      op_q      <= OP_NOP;
      a_q       <= '0;
`ifdef STACK_SEQ_EXT_OPS_EN
      b_q       <= '0;
`endif
      wait_q    <= '0;
      RES_VALID <= 1'b0;
      RES_DATA  <= '0;
      ERR       <= 1'b0;
      DEPTH_CNT <= '0;
      STK_DIN   <= '0;
      STK_WE    <= 1'b0;
      STK_RE    <= 1'b0;
    end else begin
      RES_VALID <= 1'b0;
      ERR       <= 1'b0;
      STK_WE    <= 1'b0;
      STK_RE    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (CMD_VALID) begin
            if (rej) begin
              ERR   <= 1'b1;
              op_q  <= OP_NOP;
              state <= S_DONE;
            end else begin
              op_q <= CMD_OP;
              case (CMD_OP)
                OP_NOP:  state <= S_DONE;
                OP_PUSH: begin
                  STK_WE  <= 1'b1;
                  STK_DIN <= CMD_DATA;
                  state   <= S_PUSH1;
                end
                default: begin
                  STK_RE <= 1'b1;
                  state  <= S_POP_A;
                end
              endcase
            end
          end
        end
        S_POP_A: begin
          wait_q <= WAIT_W'(POP_LAT - 1);
          state  <= S_WAIT_A;
        end
        S_WAIT_A: begin
          if (wait_q != '0) begin
            wait_q <= wait_q - WAIT_W'(1);
          end else begin
            a_q <= STK_DOUT;
            case (op_q)
              OP_POP: begin
                RES_VALID <= 1'b1;
                RES_DATA  <= STK_DOUT;
                state     <= S_DONE;
              end
              OP_ADD, OP_SUB: begin
                STK_RE <= 1'b1;
                state  <= S_POP_B;
              end
`ifdef STACK_SEQ_EXT_OPS_EN
              OP_SWAP: begin
                STK_RE <= 1'b1;
                state  <= S_POP_B;
              end
`endif
              default: begin
                // PEEK and DUP write A straight back.
                STK_WE  <= 1'b1;
                STK_DIN <= STK_DOUT;
                state   <= S_PUSH1;
              end
            endcase
          end
        end
        S_POP_B: begin
          wait_q <= WAIT_W'(POP_LAT - 1);
          state  <= S_WAIT_B;
        end
        S_WAIT_B: begin
          if (wait_q != '0) begin
            wait_q <= wait_q - WAIT_W'(1);
          end else begin
            STK_WE <= 1'b1;
            state  <= S_PUSH1;
            case (op_q)
              OP_ADD:  STK_DIN <= STK_DOUT + a_q;
              OP_SUB:  STK_DIN <= STK_DOUT - a_q;
              default: begin
                STK_DIN <= a_q;
`ifdef STACK_SEQ_EXT_OPS_EN
                b_q     <= STK_DOUT;
`endif
              end
            endcase
          end
        end
        S_PUSH1: begin
          state <= S_DONE;
          case (op_q)
            OP_ADD, OP_SUB, OP_PEEK: begin
              RES_VALID <= 1'b1;
              RES_DATA  <= STK_DIN;
            end
`ifdef STACK_SEQ_EXT_OPS_EN
            OP_DUP: begin
              STK_WE  <= 1'b1;
              STK_DIN <= a_q;
              state   <= S_PUSH2;
            end
            OP_SWAP: begin
              STK_WE  <= 1'b1;
              STK_DIN <= b_q;
              state   <= S_PUSH2;
            end
`endif
            default: ;
          endcase
        end
`ifdef STACK_SEQ_EXT_OPS_EN
        S_PUSH2: state <= S_DONE;
`endif
        S_DONE: begin
          DEPTH_CNT <= DEPTH_CNT + delta;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
